button_event_gen: RTL

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns active-low push-button presses into bus read/write bursts.
// Revision 1.0 - initial release.
`default_nettype none

module button_event_gen #(
  parameter int                 SLAVE_LEN = 2,
  parameter int                 ADDR_LEN  = 12,
  parameter int                 DATA_LEN  = 8,
  parameter int                 NUM_BTN   = 4,
  parameter int                 BURST_LEN = 1,
  parameter int                 BASE_ADDR = 0,
  parameter logic [NUM_BTN-1:0] READ_MASK = 4'b1010,
  parameter int                 TIMEOUT   = 255,
  localparam int                CH_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   button,
  input  logic [SLAVE_LEN-1:0] slave_sw,
  input  logic [DATA_LEN-1:0]  data_sw,
  input  logic [DATA_LEN-1:0]  data_in,
  input  logic                 trans_done,
  output logic [1:0]           instruction,
  output logic [SLAVE_LEN-1:0] slave_select,
  output logic [ADDR_LEN-1:0]  address,
  output logic [DATA_LEN-1:0]  data_out,
  output logic [DATA_LEN-1:0]  rx_val,
  output logic                 busy,
  output logic                 error,
  output logic [CH_W-1:0]      active_ch
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]           r_state;
  logic [NUM_BTN-1:0]   r_sync1;
  logic [NUM_BTN-1:0]   r_sync2;
  logic [NUM_BTN-1:0]   r_prev;
  logic [CH_W-1:0]      r_ch;
  logic [SLAVE_LEN-1:0] r_slave;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [DATA_LEN-1:0]  r_data;
  logic [DATA_LEN-1:0]  r_seed;
  logic [DATA_LEN-1:0]  r_rx;
  logic                 r_err;
  logic [BEAT_W-1:0]    r_beat;
  logic [WAIT_W-1:0]    r_wait;

  logic [NUM_BTN-1:0]   w_fall;
  logic                 w_any;
  logic [CH_W-1:0]      w_ch;
  logic                 w_last;
  logic                 w_timeout;
  logic                 w_read;

  function automatic logic [ADDR_LEN-1:0] f_addr(input logic [CH_W-1:0] ch,
                                                 input logic [BEAT_W-1:0] beat);
    return ADDR_LEN'(BASE_ADDR) + ADDR_LEN'(ch) * ADDR_LEN'(BURST_LEN) + ADDR_LEN'(beat);
  endfunction

  assign w_fall = r_prev & ~r_sync2;
  assign w_any  = |w_fall;

  // Scan from the top so the lowest-index falling edge wins.
  always_comb begin
    w_ch = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_fall[i]) w_ch = CH_W'(i);
    end
  end

  assign w_last    = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_read    = READ_MASK[r_ch];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_ch    <= '0;
      r_slave <= SLAVE_LEN'(1);
      r_addr  <= '0;
      r_data  <= '0;
      r_seed  <= '0;
      r_rx    <= '0;
      r_err   <= 1'b0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ISSUE;
            r_ch    <= w_ch;
            r_slave <= slave_sw;
            r_seed  <= data_sw;
            r_data  <= data_sw;
            r_addr  <= f_addr(w_ch, BEAT_W'(0));
            r_beat  <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (trans_done) begin
            if (w_read) r_rx <= data_in;
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
              r_beat  <= r_beat + BEAT_W'(1);
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_GAP: begin
          // Beat counter already advanced; present the next beat's address/data.
          r_state <= S_ISSUE;
          r_wait  <= '0;
          r_addr  <= f_addr(r_ch, r_beat);
          r_data  <= r_seed + DATA_LEN'(r_beat);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instruction  = (r_state == S_ISSUE) ? {1'b1, w_read} : 2'b00;
  assign busy         = (r_state != S_IDLE);
  assign slave_select = r_slave;
  assign address      = r_addr;
  assign data_out     = r_data;
  assign rx_val       = r_rx;
  assign error        = r_err;
  assign active_ch    = r_ch;

endmodule

`default_nettype wire
